// File: rtl/seg_disp_pkg.sv
// Shared types and constants for the multiplexed seven-segment display controller.
package seg_disp_pkg;

    typedef enum logic {
        ST_BLANK,
        ST_DRIVE
    } disp_state_t;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Active-low {dp, g..a} hex glyphs; entry 15 first, entry 0 last.
    localparam logic [15:0][7:0] GLYPH = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low seven-segment glyph, with decimal point.
module seg7_hex_decode
    import seg_disp_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] segment
);

    always_comb begin
        segment    = GLYPH[nibble];
        segment[7] = ~dp;
    end

endmodule

// File: rtl/seg_scan_display.sv
// Self-timed multiplexed seven-segment display controller with per-frame snapshot,
// inter-digit blanking and blink generation.
module seg_scan_display
    import seg_disp_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int PAGES        = 4,
    parameter int DIV          = 50000,
    parameter int BLANK        = 16,
    parameter int BLINK_FRAMES = 32
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic [PAGES*DIGITS*4-1:0]                       disp_num,
    input  logic [((PAGES > 1) ? $clog2(PAGES) : 1)-1:0]    page_sel,
    input  logic [DIGITS-1:0]                               pointing,
    input  logic [DIGITS-1:0]                               blinking,
    output logic [DIGITS-1:0]                               an,
    output logic [7:0]                                      segment,
    output logic [((DIGITS > 1) ? $clog2(DIGITS) : 1)-1:0]  digit_idx,
    output logic                                            frame_tick
);

    localparam int unsigned NW = DIGITS * 4;
    localparam int unsigned PW = (PAGES > 1) ? $clog2(PAGES) : 1;
    localparam int unsigned DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned SW = $clog2(DIV);
    localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [SW-1:0] SLOT_LAST  = SW'(DIV - 1);
    localparam logic [DW-1:0] DIGIT_LAST = DW'(DIGITS - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
    localparam disp_state_t   ST_RESET   = (BLANK > 0) ? ST_BLANK : ST_DRIVE;

    disp_state_t       state, state_next;
    logic [SW-1:0]     slot_cnt, slot_next;
    logic [DW-1:0]     digit_q;
    logic [FW-1:0]     frame_cnt;
    logic              blink_phase;
    logic              slot_wrap, frame_end, snap_en;

    logic [NW-1:0]     num_snap, num_view, page_word;
    logic [DIGITS-1:0] point_snap, point_view;
    logic [DIGITS-1:0] blink_snap, blink_view;
    logic [3:0]        cur_nibble;
    logic [7:0]        glyph;

    logic [DIGITS-1:0] an_next, an_q;
    logic [7:0]        seg_next, seg_q;
    logic              tick_q;

    assign slot_wrap = (slot_cnt == SLOT_LAST);
    assign frame_end = slot_wrap && (digit_q == DIGIT_LAST);
    assign snap_en   = (digit_q == '0) && (slot_cnt == '0);
    assign slot_next = slot_wrap ? '0 : slot_cnt + 1'b1;

    always_comb begin
        page_word = disp_num[NW-1:0];
        for (int unsigned p = 1; p < PAGES; p++) begin
            if (page_sel == PW'(p)) page_word = disp_num[p*NW +: NW];
        end
    end

    // On the snapshot edge the registers still hold last frame, so forward the
    // values being captured; a frame never mixes old and new data.
    assign num_view   = snap_en ? page_word : num_snap;
    assign point_view = snap_en ? pointing  : point_snap;
    assign blink_view = snap_en ? blinking  : blink_snap;
    assign cur_nibble = num_view[4*digit_q +: 4];

    seg7_hex_decode u_decode (
        .nibble  (cur_nibble),
        .dp      (point_view[digit_q]),
        .segment (glyph)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_RESET;
        else     state <= state_next;
    end

    always_comb begin
        state_next = (int'(slot_next) < BLANK) ? ST_BLANK : ST_DRIVE;
        an_next    = '1;
        seg_next   = SEG_OFF;
        if (state == ST_DRIVE) begin
            seg_next = glyph;
            if (!(blink_phase && blink_view[digit_q])) an_next[digit_q] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt    <= '0;
            digit_q     <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            num_snap    <= '0;
            point_snap  <= '0;
            blink_snap  <= '0;
            an_q        <= '1;
            seg_q       <= SEG_OFF;
            tick_q      <= 1'b0;
        end else begin
            slot_cnt <= slot_next;
            if (slot_wrap) digit_q <= (digit_q == DIGIT_LAST) ? '0 : digit_q + 1'b1;
            if (frame_end) begin
                frame_cnt <= (frame_cnt == FRAME_LAST) ? '0 : frame_cnt + 1'b1;
                if (frame_cnt == FRAME_LAST) blink_phase <= ~blink_phase;
            end
            if (snap_en) begin
                num_snap   <= page_word;
                point_snap <= pointing;
                blink_snap <= blinking;
            end
            an_q   <= an_next;
            seg_q  <= seg_next;
            tick_q <= snap_en;
        end
    end

    assign an         = an_q;
    assign segment    = seg_q;
    assign digit_idx  = digit_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed self-checking bench for seg_scan_display (DIGITS=4, PAGES=4, DIV=8, BLANK=2, BLINK_FRAMES=2).
module tb_seg_scan_display;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] disp_num;
    logic [1:0]  page_sel;
    logic [3:0]  pointing;
    logic [3:0]  blinking;
    logic [3:0]  an;
    logic [7:0]  segment;
    logic [1:0]  digit_idx;
    logic        frame_tick;

    int tests = 0;
    int fails = 0;
    int n     = 0;

    logic [7:0] glyph_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                   8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    always #5 clk = ~clk;

    seg_scan_display #(
        .DIGITS       (4),
        .PAGES        (4),
        .DIV          (8),
        .BLANK        (2),
        .BLINK_FRAMES (2)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .disp_num   (disp_num),
        .page_sel   (page_sel),
        .pointing   (pointing),
        .blinking   (blinking),
        .an         (an),
        .segment    (segment),
        .digit_idx  (digit_idx),
        .frame_tick (frame_tick)
    );

    // Sample k is taken after the k-th edge following reset release; it shows
    // slot k%8 of digit (k/8)%4 in frame k/32, blink phase toggling every 2 frames.
    function automatic logic [3:0] exp_an(input int k, input logic [3:0] blk);
        int d = (k / 8) % 4;
        int f = k / 32;
        if ((k % 8) < 2) return 4'b1111;
        if (((f / 2) % 2) == 1 && blk[d]) return 4'b1111;
        return ~(4'b0001 << d);
    endfunction

    function automatic logic [7:0] exp_seg(input int k, input logic [15:0] word, input logic [3:0] pt);
        int d = (k / 8) % 4;
        logic [7:0] g;
        if ((k % 8) < 2) return 8'hFF;
        g    = glyph_tab[word[d*4 +: 4]];
        g[7] = ~pt[d];
        return g;
    endfunction

    task automatic step();
        @(negedge clk);
        n++;
    endtask

    task automatic release_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n = 0;
    endtask

    task automatic test_reset();
        disp_num = {16'h0000, 16'hABCD, 16'h0000, 16'h1234};
        page_sel = 2'd0;
        pointing = 4'b0000;
        blinking = 4'b0000;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests++; if (an !== 4'b1111) begin fails++; $display("FAIL reset_an got %b want 1111", an); end
        tests++; if (segment !== 8'hFF) begin fails++; $display("FAIL reset_seg got %h want ff", segment); end
        tests++; if (frame_tick !== 1'b0) begin fails++; $display("FAIL reset_tick got %b want 0", frame_tick); end
        tests++; if (digit_idx !== 2'd0) begin fails++; $display("FAIL reset_digit got %0d want 0", digit_idx); end
        rst = 1'b0;
        @(negedge clk);
        n = 0;
        tests++; if (frame_tick !== 1'b1) begin fails++; $display("FAIL reset_first_tick got %b want 1", frame_tick); end
        step();
        tests++; if (frame_tick !== 1'b0) begin fails++; $display("FAIL reset_tick_width got %b want 0", frame_tick); end
    endtask

    task automatic test_scan_order();
        logic [7:0] seg_tab [4] = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
        logic [3:0] e_an;
        logic [7:0] e_seg;
        release_reset();
        for (int k = 0; k < 64; k++) begin
            if ((n % 8) < 2) begin e_an = 4'b1111; e_seg = 8'hFF; end
            else begin e_an = ~(4'b0001 << ((n / 8) % 4)); e_seg = seg_tab[(n / 8) % 4]; end
            tests++; if (an !== e_an) begin fails++; $display("FAIL scan_an n=%0d got %b want %b", n, an, e_an); end
            tests++; if (segment !== e_seg) begin fails++; $display("FAIL scan_seg n=%0d got %h want %h", n, segment, e_seg); end
            tests++; if (frame_tick !== ((n % 32) == 0)) begin fails++; $display("FAIL scan_tick n=%0d got %b", n, frame_tick); end
            tests++; if (digit_idx !== 2'(((n + 1) / 8) % 4)) begin fails++; $display("FAIL scan_digit n=%0d got %0d want %0d", n, digit_idx, ((n + 1) / 8) % 4); end
            step();
        end
    endtask

    task automatic test_page_switch();
        logic [15:0] word;
        release_reset();
        for (int k = 0; k < 96; k++) begin
            if (n == 10) page_sel = 2'd2;
            word = (n < 32) ? 16'h1234 : 16'hABCD;
            tests++; if (an !== exp_an(n, 4'b0000)) begin fails++; $display("FAIL page_an n=%0d got %b want %b", n, an, exp_an(n, 4'b0000)); end
            tests++; if (segment !== exp_seg(n, word, 4'b0000)) begin fails++; $display("FAIL page_seg n=%0d got %h want %h", n, segment, exp_seg(n, word, 4'b0000)); end
            step();
        end
        page_sel = 2'd0;
    endtask

    task automatic test_snapshot_edge();
        logic [15:0] word;
        release_reset();
        for (int k = 0; k < 64; k++) begin
            if (n == 31) begin
                page_sel = 2'd1;
                disp_num[31:16] = 16'h5678;
            end
            word = (n < 32) ? 16'h1234 : 16'h5678;
            tests++; if (segment !== exp_seg(n, word, 4'b0000)) begin fails++; $display("FAIL snapedge_seg n=%0d got %h want %h", n, segment, exp_seg(n, word, 4'b0000)); end
            step();
        end
        page_sel = 2'd0;
    endtask

    task automatic test_blink();
        blinking = 4'b0001;
        release_reset();
        for (int k = 0; k < 256; k++) begin
            tests++; if (an !== exp_an(n, 4'b0001)) begin fails++; $display("FAIL blink_an n=%0d got %b want %b", n, an, exp_an(n, 4'b0001)); end
            tests++; if (segment !== exp_seg(n, 16'h1234, 4'b0000)) begin fails++; $display("FAIL blink_seg n=%0d got %h want %h", n, segment, exp_seg(n, 16'h1234, 4'b0000)); end
            step();
        end
        blinking = 4'b0000;
    endtask

    task automatic test_decimal_point();
        logic e_dp;
        pointing = 4'b0100;
        release_reset();
        for (int k = 0; k < 64; k++) begin
            e_dp = ((n % 8) >= 2 && ((n / 8) % 4) == 2) ? 1'b0 : 1'b1;
            tests++; if (segment[7] !== e_dp) begin fails++; $display("FAIL dp_bit n=%0d got %b want %b (an=%b)", n, segment[7], e_dp, an); end
            tests++; if (segment !== exp_seg(n, 16'h1234, 4'b0100)) begin fails++; $display("FAIL dp_seg n=%0d got %h want %h", n, segment, exp_seg(n, 16'h1234, 4'b0100)); end
            step();
        end
        pointing = 4'b0000;
    endtask

    task automatic test_mid_reset();
        blinking = 4'b0001;
        release_reset();
        while (n < 84) begin
            tests++; if (an !== exp_an(n, 4'b0001)) begin fails++; $display("FAIL midrst_pre_an n=%0d got %b want %b", n, an, exp_an(n, 4'b0001)); end
            step();
        end
        tests++; if (an !== 4'b1011) begin fails++; $display("FAIL midrst_digit2 got %b want 1011", an); end
        rst = 1'b1;
        @(negedge clk);
        tests++; if (an !== 4'b1111) begin fails++; $display("FAIL midrst_an got %b want 1111", an); end
        tests++; if (segment !== 8'hFF) begin fails++; $display("FAIL midrst_seg got %h want ff", segment); end
        tests++; if (digit_idx !== 2'd0) begin fails++; $display("FAIL midrst_digit got %0d want 0", digit_idx); end
        tests++; if (frame_tick !== 1'b0) begin fails++; $display("FAIL midrst_tick got %b want 0", frame_tick); end
        rst = 1'b0;
        @(negedge clk);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            tests++; if (an !== exp_an(n, 4'b0001)) begin fails++; $display("FAIL midrst_post_an n=%0d got %b want %b", n, an, exp_an(n, 4'b0001)); end
            tests++; if (frame_tick !== ((n % 32) == 0)) begin fails++; $display("FAIL midrst_post_tick n=%0d got %b", n, frame_tick); end
            step();
        end
        blinking = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_scan_order();
        test_page_switch();
        test_snapshot_edge();
        test_blink();
        test_decimal_point();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seg_scan_display.md
# seg_scan_display

Parametrised, self-timed multiplexed seven-segment display controller for the calculator/ALU debug boards. It holds its own scan divider, digit sequencer, inter-digit blanking (anti-ghosting) and blink generator. It latches the selected page of the display word once per frame so that page switches and data updates never tear mid-frame. It sits between the datapath result registers and the board's active-low anode/segment pins and replaces the externally scanned combinational display decoder.

## Interface
- DIGITS, 4: number of digits; 2..8.
- PAGES, 4: number of selectable DIGITS-nibble pages in disp_num; 1..8.
- DIV, 50000: clk cycles per digit slot; ≥ 2.
- BLANK, 16: cycles at the start of each slot with all anodes off; 0..DIV-1.
- BLINK_FRAMES, 32: frames per blink half-period; ≥ 1.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- disp_num  in  PAGES*DIGITS*4  page p = bits [(p+1)*DIGITS*4-1 : p*DIGITS*4]; digit 0 = lowest nibble
- page_sel  in  max(1,$clog2(PAGES))  page to display; values ≥ PAGES select page 0
- pointing  in  DIGITS  decimal point lit for digit i when bit i = 1
- blinking  in  DIGITS  digit i blanked during blink-off phase when bit i = 1
- an  out  DIGITS  anodes, active-low, one-cold or all-ones
- segment  out  8  {dp, g..a}, active-low
- digit_idx  out  max(1,$clog2(DIGITS))  digit currently in its slot
- frame_tick  out  1  one-cycle pulse per frame snapshot

## Operation
- Counters:
  - slot_cnt counts 0..DIV-1, then wraps.
  - digit_idx increments when slot_cnt wraps; it wraps DIGITS-1 → 0.
  - frame_cnt counts frames 0..BLINK_FRAMES-1. On wrap, blink_phase toggles.
- FSM, states BLANK and DRIVE:
  - BLANK while slot_cnt < BLANK; DRIVE otherwise.
  - With BLANK=0, BLANK is never entered after reset exits.
- Snapshot: on the cycle where digit_idx=0 and slot_cnt=0, register:
  - the selected page of disp_num
  - pointing
  - blinking
- Drive values come only from the snapshot. Input changes at any other time have no visible effect until the next frame.
- Decode uses the standard hex glyph table, active-low:
  - 0 = C0, 1 = F9, 2 = A4, 3 = B0, 4 = 99, 5 = 92, 6 = 82, 7 = F8
  - 8 = 80, 9 = 90, A = 88, b = 83, C = C6, d = A1, E = 86, F = 8E
  - segment[7] = ~pointing_snap[digit_idx].
- BLANK state: an = all ones, segment = 8'hFF.
- DRIVE state:
  - an = ~(1 << digit_idx).
  - If blink_phase=1 and blinking_snap[digit_idx]=1, an is held all ones; segment still carries the glyph.
- Reset (at any point, including mid-slot) forces in the same edge:
  - all counters to 0
  - blink_phase to 0
  - snapshot registers to 0
  - state to BLANK (or DRIVE if BLANK=0)
- Reset values: an = all ones, segment = 8'hFF, digit_idx = 0, frame_tick = 0.

## Timing
- an and segment are registered. They reflect the counter/FSM state of the previous cycle, so output latency is 1 cycle.
- frame_tick is registered, high for exactly the cycle after the snapshot edge.
- digit_idx is the live counter with no extra latency.
- First post-reset snapshot: the first rising edge with rst=0. frame_tick is then high on the next cycle.
- Frame length = DIGITS*DIV cycles. Blink period = 2*BLINK_FRAMES frames.
- In each slot, an is all ones for BLANK cycles and then one-cold for DIV-BLANK cycles, both offset by the 1-cycle output latency.
- A page_sel or disp_num change that lands on the snapshot edge itself is captured.

## Structure
- Package seg_disp_pkg holds:
  - the state enum {ST_BLANK, ST_DRIVE}
  - the 16-entry active-low glyph constant array
  - the SEG_OFF = 8'hFF constant
- One sub-module, seg7_hex_decode: combinational, 4-bit nibble + dp in → 8-bit active-low segment out, built from the package table.
- Counters, FSM, snapshot and output registers live in the top module.

## Test plan
Parameters for all scenarios: DIGITS=4, PAGES=4, DIV=8, BLANK=2, BLINK_FRAMES=2.

- **Reset:** hold rst for 3 cycles → an=4'b1111, segment=8'hFF, frame_tick=0, digit_idx=0. Release → frame_tick=1 exactly one cycle later.
- **Scan order:** page 0 = 16'h1234, page_sel=0 → per slot, 2 cycles of an=1111/segment=FF, then 6 cycles of each pair in turn:
  - an=1110 / segment=99
  - an=1101 / segment=B0
  - an=1011 / segment=A4
  - an=0111 / segment=F9
  - Then repeat, with frame_tick every 32 cycles.
- **Page switch mid-frame:** page 2 = 16'hABCD; set page_sel=2 while digit_idx=1 → remaining slots of this frame still show 3, 2, 1. From the next frame on, the display shows D, C, b, A.
- **Blink:** blinking=4'b0001 → an[0] never low during frames 2–3, 6–7, …; an[0] low in the DRIVE cycles of frames 0–1, 4–5. Digits 1–3 are unaffected.
- **Decimal point:** pointing=4'b0100 → segment[7]=0 only while an=1011; it is 1 in every other cycle.
- **Mid-operation reset:** assert rst during digit 2 DRIVE → next cycle an=1111, segment=FF, digit_idx=0. After release, the scan restarts at digit 0 with blink_phase=0.
